// File: rtl/mips_mem_pkg.sv
// Shared memory-path definitions: access-size encodings, the store entry
// layout and the lane decode used by both the store narrowing and load lane select.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Address field is carried at 32 bits; narrower address widths are zero-extended.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        lossy;
    } entry_t;

    // Size/alignment legality: halfwords need addr[0]=0, words need addr[1:0]=00.
    function automatic logic store_legal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: store_legal = 1'b1;
            SZ_HALF: store_legal = ~lo[0];
            SZ_WORD: store_legal = (lo == 2'b00);
            default: store_legal = 1'b0;
        endcase
    endfunction

    // Byte enables, lane-replicated data and lossy flag; addr is left zero for the caller.
    function automatic entry_t lane_decode(input logic [1:0] size, input logic [1:0] lo,
                                           input logic [31:0] data);
        entry_t e;
        e = '0;
        case (size)
            SZ_BYTE: begin
                e.be    = 4'b0001 << lo;
                e.wdata = {4{data[7:0]}};
                e.lossy = (data[31:8] != {24{data[7]}});
            end
            SZ_HALF: begin
                e.be    = lo[1] ? 4'b1100 : 4'b0011;
                e.wdata = {2{data[15:0]}};
                e.lossy = (data[31:16] != {16{data[15]}});
            end
            SZ_WORD: begin
                e.be    = 4'b1111;
                e.wdata = data;
                e.lossy = 1'b0;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic DEPTH x WIDTH synchronous circular FIFO with full/empty/count.
// Pushes when full and pops when empty are ignored.
module store_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data-only and needs no reset; reads of empty slots are masked by the user.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Occupancy bound; an underflow would wrap count above DEPTH and trip this as well.
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(do_pop && empty));

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: decodes SB/SH/SW requests into byte enables and
// lane-replicated write data, queues legal beats, and pulses an error for
// illegal sizes or misaligned accesses.
module store_narrow_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_addr,
    input  logic [31:0]            req_data,
    input  logic [1:0]             req_size,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    output logic                   mem_lossy,
    output logic                   err_valid,
    output logic [AW-1:0]          err_addr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int EW = $bits(entry_t);

    logic   legal;
    logic   accept;
    logic   push;
    logic   pop;
    logic   full;
    logic   empty;
    entry_t in_e;
    entry_t out_e;

    assign legal     = store_legal(req_size, req_addr[1:0]);
    assign req_ready = ~full;
    assign accept    = req_valid & req_ready;
    assign push      = accept & legal;
    assign mem_valid = ~empty;
    assign pop       = mem_valid & mem_ready;

    // Decode the incoming request into a word-aligned queue entry.
    always_comb begin
        in_e      = lane_decode(req_size, req_addr[1:0], req_data);
        in_e.addr = 32'({req_addr[AW-1:2], 2'b00});
    end

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_e),
        .pop   (pop),
        .rdata (out_e),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Head entry drives the port; outputs read zero while the queue is empty.
    assign mem_addr  = empty ? '0 : AW'(out_e.addr);
    assign mem_wdata = empty ? '0 : out_e.wdata;
    assign mem_be    = empty ? '0 : out_e.be;
    assign mem_lossy = empty ? 1'b0 : out_e.lossy;

    // One-cycle error pulse for accepted-but-rejected requests; address held until the next error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else begin
            err_valid <= accept & ~legal;
            if (accept & ~legal) err_addr <= req_addr;
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
module tb_store_narrow_unit;
    localparam int DEPTH = 2;
    localparam int AW    = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_valid;
    logic                   req_ready;
    logic [AW-1:0]          req_addr;
    logic [31:0]            req_data;
    logic [1:0]             req_size;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [AW-1:0]          mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_be;
    logic                   mem_lossy;
    logic                   err_valid;
    logic [AW-1:0]          err_addr;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic          lossy;
    } beat_t;

    beat_t         exp_q[$];
    bit            err_pend = 1'b0;
    logic [AW-1:0] err_exp  = '0;

    always #5 clk = ~clk;

    store_narrow_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_lossy (mem_lossy),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .count     (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what a store of this size does to memory, from plain arithmetic.
    function automatic bit model(input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [1:0] sz, output beat_t b);
        int off;
        int sv;
        off     = int'(a % 4);
        sv      = $signed(d);
        b.addr  = (a / 4) * 4;
        b.wdata = '0;
        b.be    = '0;
        b.lossy = 1'b0;
        case (sz)
            2'd0: begin
                b.be    = 4'(1 << off);
                b.wdata = 32'h01010101 * d[7:0];
                b.lossy = (sv < -128) || (sv > 127);
                return 1'b1;
            end
            2'd1: begin
                if (off % 2 != 0) return 1'b0;
                b.be    = (off == 2) ? 4'b1100 : 4'b0011;
                b.wdata = 32'h00010001 * d[15:0];
                b.lossy = (sv < -32768) || (sv > 32767);
                return 1'b1;
            end
            2'd2: begin
                if (off != 0) return 1'b0;
                b.be    = 4'b1111;
                b.wdata = d;
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    // Monitor / scoreboard: compare against the model, then predict the next edge.
    always @(negedge clk) begin
        beat_t b;
        bit    acc;
        bit    do_pop;
        if (rst) begin
            exp_q.delete();
            err_pend = 1'b0;
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_err_valid", err_valid, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_be", mem_be, 0);
            chk("rst_mem_addr", mem_addr, 0);
        end else begin
            chk("count", count, exp_q.size());
            chk("req_ready", req_ready, exp_q.size() != DEPTH);
            chk("mem_valid", mem_valid, exp_q.size() != 0);
            chk("err_valid", err_valid, err_pend);
            if (err_pend) chk("err_addr", err_addr, err_exp);
            if (exp_q.size() != 0) begin
                chk("mem_addr", mem_addr, exp_q[0].addr);
                chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                chk("mem_be", mem_be, exp_q[0].be);
                chk("mem_lossy", mem_lossy, exp_q[0].lossy);
            end
            acc    = req_valid && (exp_q.size() != DEPTH);
            do_pop = (exp_q.size() != 0) && mem_ready;
            if (do_pop) void'(exp_q.pop_front());
            err_pend = 1'b0;
            if (acc) begin
                if (model(req_addr, req_data, req_size, b)) begin
                    exp_q.push_back(b);
                end else begin
                    err_pend = 1'b1;
                    err_exp  = req_addr;
                end
            end
        end
    end

    // Hold a request until it is taken; bounded wait.
    task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL send_timeout: addr %0h not accepted within 100 cycles", a);
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] h_addr;
        logic [31:0]   h_wdata;
        logic [3:0]    h_be;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Byte store to the top lane
        send(32'h1003, 32'hFFFFFF80, 2'b00);
        @(negedge clk);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'h80808080);
        chk("sb_lossy", mem_lossy, 1'b0);
        @(posedge clk); #1;

        // Lossy halfword, then full word
        send(32'h2002, 32'h00012345, 2'b01);
        @(negedge clk);
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'h23452345);
        chk("sh_lossy", mem_lossy, 1'b1);
        @(posedge clk); #1;
        send(32'h2004, 32'hDEADBEEF, 2'b10);
        @(negedge clk);
        chk("sw_be", mem_be, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_lossy", mem_lossy, 1'b0);
        @(posedge clk); #1;

        // Misaligned word and illegal size
        send(32'h3001, 32'h12345678, 2'b10);
        @(negedge clk);
        chk("mis_err_valid", err_valid, 1'b1);
        chk("mis_err_addr", err_addr, 32'h3001);
        chk("mis_mem_valid", mem_valid, 1'b0);
        @(negedge clk);
        chk("mis_err_clear", err_valid, 1'b0);
        @(posedge clk); #1;
        send(32'h3000, 32'h12345678, 2'b11);
        @(negedge clk);
        chk("ill_err_valid", err_valid, 1'b1);
        chk("ill_err_addr", err_addr, 32'h3000);
        chk("ill_count", count, 0);
        @(posedge clk); #1;

        // Back-pressure: fill, stall, drain
        mem_ready = 1'b0;
        send(32'h4000, 32'h00000011, 2'b00);
        send(32'h4002, 32'hFFFF8001, 2'b01);
        req_valid = 1'b1; req_addr = 32'h4008; req_data = 32'hCAFEF00D; req_size = 2'b10;
        @(negedge clk);
        chk("full_ready", req_ready, 1'b0);
        chk("full_count", count, 2);
        h_addr = mem_addr; h_wdata = mem_wdata; h_be = mem_be;
        repeat (3) @(negedge clk);
        chk("stall_addr", mem_addr, h_addr);
        chk("stall_wdata", mem_wdata, h_wdata);
        chk("stall_be", mem_be, h_be);
        @(posedge clk); #1 mem_ready = 1'b1;
        send(32'h4008, 32'hCAFEF00D, 2'b10);
        repeat (4) @(posedge clk); #1;

        // Streaming words, one per cycle
        for (int i = 0; i < 10; i++) send(32'h5000 + 4 * i, $urandom, 2'b10);
        repeat (3) @(posedge clk); #1;

        // Asynchronous reset with two queued entries
        mem_ready = 1'b0;
        send(32'h6000, 32'h1, 2'b10);
        send(32'h6004, 32'h2, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_valid", mem_valid, 1'b0);
        chk("arst_count", count, 0);
        @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", mem_valid, 1'b0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 32'h7000 + $urandom_range(0, 31);
            case ($urandom_range(0, 2))
                0: req_data = $urandom;
                1: req_data = {{24{req_data[7]}}, 8'($urandom)};
                default: req_data = 32'($signed(16'($urandom)));
            endcase
            req_size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            mem_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1 req_valid = 1'b0; mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drained", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
